// File: rtl/breath_pkg.sv
// Shared encodings for the breathing-LED sequencer: modes, FSM states, ramp phase.
package breath_pkg;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned DIV_W  = 6;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SYNC  = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_ON    = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        PH_UP   = 1'b0,
        PH_DOWN = 1'b1
    } phase_e;

endpackage

// File: rtl/breath_timebase.sv
// PWM time base: clock divider to 1 us slots, and a slot counter spanning one 1 ms frame.
module breath_timebase
    import breath_pkg::*;
#(
    parameter logic [DIV_W-1:0] CNT_1US_MAX = 6'd49,
    parameter logic [CNT_W-1:0] CNT_1MS_MAX = 10'd999
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             ms_tick_c,
    output logic [CNT_W-1:0] slot_cnt
);

    logic [DIV_W-1:0] slot_div_q, slot_div_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic             us_tick;

    // Counters only move while enabled; a clear or disable parks them at zero.
    always_comb begin
        slot_div_d = slot_div_q;
        slot_cnt_d = slot_cnt_q;
        us_tick    = en && (slot_div_q == CNT_1US_MAX);
        ms_tick_c  = us_tick && (slot_cnt_q == CNT_1MS_MAX);
        if (clr || !en) begin
            slot_div_d = '0;
            slot_cnt_d = '0;
        end else if (us_tick) begin
            slot_div_d = '0;
            slot_cnt_d = ms_tick_c ? '0 : slot_cnt_q + CNT_W'(1);
        end else begin
            slot_div_d = slot_div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_div_q <= '0;
            slot_cnt_q <= '0;
        end else begin
            slot_div_q <= slot_div_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign slot_cnt = slot_cnt_q;

endmodule

// File: rtl/breath_seq_ctrl.sv
// Breathing-LED sequencer: run/idle FSM, shared triangle duty ramp and per-mode LED mapping.
module breath_seq_ctrl
    import breath_pkg::*;
#(
    parameter logic [DIV_W-1:0] CNT_1US_MAX = 6'd49,
    parameter logic [CNT_W-1:0] CNT_1MS_MAX = 10'd999,
    parameter logic [CNT_W-1:0] STEP_MAX    = 10'd999,
    parameter int unsigned      LED_NUM     = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_pulse,
    input  logic               stop_pulse,
    input  logic [MODE_W-1:0]  mode,
    output logic [LED_NUM-1:0] led_out,
    output logic               busy,
    output logic               cycle_done
);

    localparam int unsigned IDX_W = $clog2(LED_NUM);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic [IDX_W-1:0]   led_idx_q, led_idx_d;
    logic [LED_NUM-1:0] led_out_q, led_out_d;
    logic               busy_q, busy_d;
    logic               cycle_done_q, cycle_done_d;

    logic               start_run;
    logic               run;
    logic               tb_clr;
    logic               ms_tick_c;
    logic [CNT_W-1:0]   slot_cnt;
    logic               lit;

    assign run       = (state_q == ST_RUN);
    assign start_run = start_pulse && !stop_pulse;
    assign tb_clr    = (state_d != ST_RUN) || start_run;
    assign lit       = (slot_cnt < duty_q);

    breath_timebase #(
        .CNT_1US_MAX (CNT_1US_MAX),
        .CNT_1MS_MAX (CNT_1MS_MAX)
    ) u_timebase (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (run),
        .clr       (tb_clr),
        .ms_tick_c (ms_tick_c),
        .slot_cnt  (slot_cnt)
    );

    // Stop dominates start; start while running is a full restart.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        phase_d      = phase_q;
        duty_d       = duty_q;
        led_idx_d    = led_idx_q;
        led_out_d    = '0;
        cycle_done_d = 1'b0;

        if (stop_pulse) begin
            state_d = ST_IDLE;
        end else if (start_pulse) begin
            state_d = ST_RUN;
        end
        busy_d = (state_d == ST_RUN);

        if (state_d != ST_RUN) begin
            phase_d   = PH_UP;
            duty_d    = '0;
            led_idx_d = '0;
        end else if (start_run) begin
            mode_d    = mode_e'(mode);
            phase_d   = PH_UP;
            duty_d    = '0;
            led_idx_d = '0;
        end else if (ms_tick_c) begin
            if (phase_q == PH_UP) begin
                duty_d = duty_q + CNT_W'(1);
                if (duty_q + CNT_W'(1) == STEP_MAX) begin
                    phase_d = PH_DOWN;
                end
            end else begin
                duty_d = duty_q - CNT_W'(1);
                if (duty_q == CNT_W'(1)) begin
                    // Breath cycle complete: new mode takes effect from the next frame.
                    phase_d      = PH_UP;
                    cycle_done_d = 1'b1;
                    mode_d       = mode_e'(mode);
                    if (mode_q == MODE_CHASE) begin
                        led_idx_d = (led_idx_q == IDX_W'(LED_NUM - 1)) ? '0
                                                                       : led_idx_q + IDX_W'(1);
                    end
                end
            end
        end

        if (run) begin
            case (mode_q)
                MODE_SYNC:  led_out_d = {LED_NUM{lit}};
                MODE_CHASE: led_out_d = LED_NUM'(lit) << led_idx_q;
                MODE_ON:    led_out_d = '1;
                default:    led_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SYNC;
            phase_q      <= PH_UP;
            duty_q       <= '0;
            led_idx_q    <= '0;
            led_out_q    <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            led_idx_q    <= led_idx_d;
            led_out_q    <= led_out_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign led_out    = led_out_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;

endmodule
